// File: rtl/aes_sbox_scheduler.sv
// ---------------------------------------------------------------------------
// aes_sbox_scheduler
//
// Purpose:
//   Shares one narrow bank of LANES combinational AES S-boxes between the
//   round datapath (128-bit SubBytes) and the key expansion (32-bit SubWord).
//   A state request is latched and pushed through the bank LANES bytes per
//   cycle (BEATS = 16/LANES cycles). Each result slice is written back over
//   the operand slice it came from. A key request takes a single bank cycle.
//
// Parameters:
//   LANES          number of byte S-boxes in the bank (4, 8 or 16)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   st_valid/st_ready/st_data          round-datapath request handshake + state
//   st_out_valid/st_out_data           1-cycle result pulse + held result
//   key_valid/key_ready/key_word       key-schedule request handshake + word
//   key_out_valid/key_out_word         1-cycle result pulse + held SubWord
//   sbox_in        operand bytes to the shared bank (registered, 0 when idle)
//   sbox_out       bank result, lane i = S(sbox_in lane i), same cycle
//
// Configuration macro:
//   AES_SBOX_SCHED_KEY_PRIO_EN  when defined, key requests always win
//                               arbitration and the round-robin pointer is
//                               removed; otherwise round-robin arbitration.
// ---------------------------------------------------------------------------
module aes_sbox_scheduler #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [127:0]       st_data,
    output logic               st_out_valid,
    output logic [127:0]       st_out_data,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [31:0]        key_word,
    output logic               key_out_valid,
    output logic [31:0]        key_out_word,
    output logic [LANES*8-1:0] sbox_in,
    input  logic [LANES*8-1:0] sbox_out
);

    localparam int BEATS = 16 / LANES;
    localparam int SW    = LANES * 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
            $error("aes_sbox_scheduler: LANES must be 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ST_BUSY  = 2'd1,
        KEY_BUSY = 2'd2
    } state_e;

    state_e            state_q,         state_d;
    logic [BW-1:0]     beat_q,          beat_d;
    logic [127:0]      op_q,            op_d;
    logic [SW-1:0]     sbox_in_q,       sbox_in_d;
    logic              st_out_valid_q,  st_out_valid_d;
    logic [127:0]      st_out_data_q,   st_out_data_d;
    logic              key_out_valid_q, key_out_valid_d;
    logic [31:0]       key_out_word_q,  key_out_word_d;
    logic              st_accept;
    logic              key_accept;

`ifndef AES_SBOX_SCHED_KEY_PRIO_EN
    // 0: state requester is favoured next, 1: key requester is favoured next
    logic              rr_ptr_q,        rr_ptr_d;
`endif

    // Grant logic: readies only in IDLE (and never during reset), at most one high.
    always_comb begin
        st_ready  = 1'b0;
        key_ready = 1'b0;
        if (!rst && state_q == IDLE) begin
`ifdef AES_SBOX_SCHED_KEY_PRIO_EN
            key_ready = key_valid;
            st_ready  = st_valid & ~key_valid;
`else
            if (st_valid && key_valid) begin
                st_ready  = ~rr_ptr_q;
                key_ready = rr_ptr_q;
            end else begin
                st_ready  = st_valid;
                key_ready = key_valid;
            end
`endif
        end else begin
            st_ready  = 1'b0;
            key_ready = 1'b0;
        end
    end

    assign st_accept  = st_valid & st_ready;
    assign key_accept = key_valid & key_ready;

`ifndef AES_SBOX_SCHED_KEY_PRIO_EN
    // Round-robin pointer: after any grant, favour the other requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (st_accept) begin
            rr_ptr_d = 1'b1;
        end else if (key_accept) begin
            rr_ptr_d = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register; reset favours the state requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Next-state, beat sequencing, bank operand selection and result capture.
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        op_d            = op_q;
        sbox_in_d       = '0;
        st_out_valid_d  = 1'b0;
        st_out_data_d   = st_out_data_q;
        key_out_valid_d = 1'b0;
        key_out_word_d  = key_out_word_q;
        case (state_q)
            IDLE: begin
                if (st_accept) begin
                    // sbox_in is registered, so the first slice is staged now.
                    op_d      = st_data;
                    sbox_in_d = st_data[SW-1:0];
                    beat_d    = '0;
                    state_d   = ST_BUSY;
                end else if (key_accept) begin
                    sbox_in_d        = '0;
                    sbox_in_d[31:0]  = key_word;
                    state_d          = KEY_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            ST_BUSY: begin
                // Result overwrites the operand slice it was computed from.
                op_d[int'(beat_q)*SW +: SW] = sbox_out;
                if (beat_q == LAST_BEAT) begin
                    beat_d         = '0;
                    state_d        = IDLE;
                    st_out_valid_d = 1'b1;
                    st_out_data_d  = op_d;
                end else begin
                    beat_d    = beat_q + BW'(1);
                    sbox_in_d = op_q[(int'(beat_q) + 1)*SW +: SW];
                    state_d   = ST_BUSY;
                end
            end
            KEY_BUSY: begin
                key_out_word_d  = sbox_out[31:0];
                key_out_valid_d = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Datapath and FSM registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            op_q            <= '0;
            sbox_in_q       <= '0;
            st_out_valid_q  <= 1'b0;
            st_out_data_q   <= '0;
            key_out_valid_q <= 1'b0;
            key_out_word_q  <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            op_q            <= op_d;
            sbox_in_q       <= sbox_in_d;
            st_out_valid_q  <= st_out_valid_d;
            st_out_data_q   <= st_out_data_d;
            key_out_valid_q <= key_out_valid_d;
            key_out_word_q  <= key_out_word_d;
        end
    end

    assign sbox_in       = sbox_in_q;
    assign st_out_valid  = st_out_valid_q;
    assign st_out_data   = st_out_data_q;
    assign key_out_valid = key_out_valid_q;
    assign key_out_word  = key_out_word_q;

endmodule
